// File: rtl/hysteresis_thresh.sv
// Canny hysteresis stage: double-threshold classification with a one-pass
// strong-neighbour check over a 3x3 window, emitting a 0/255 edge map.
module hysteresis_thresh #(
  parameter int WIDTH       = 720,
  parameter int HEIGHT      = 540,
  parameter int HIGH_THRESH = 48,
  parameter int LOW_THRESH  = 12
) (
  input  logic       clock,
  input  logic       reset,
  output logic       in_rd_en,
  input  logic       in_empty,
  input  logic [7:0] in_dout,
  output logic       out_wr_en,
  input  logic       out_full,
  output logic [7:0] out_din
);

  localparam int SR_LEN = 2 * WIDTH + 2;
  localparam int PIXELS = WIDTH * HEIGHT;
  localparam int CNT_W  = $clog2(PIXELS + 1);
  localparam int COL_W  = $clog2(WIDTH);
  localparam int ROW_W  = $clog2(HEIGHT);

  localparam logic [7:0]       HI_TH     = 8'(HIGH_THRESH);
  localparam logic [7:0]       LO_TH     = 8'(LOW_THRESH);
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(PIXELS - 1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(HEIGHT - 1);

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_WEAK   = 2'd1,
    CLS_STRONG = 2'd2
  } cls_t;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t           state, next_state;
  cls_t             sr [SR_LEN];
  cls_t             in_class, shift_class, centre;
  logic [CNT_W-1:0] in_count;
  logic [COL_W-1:0] out_col;
  logic [ROW_W-1:0] out_row;
  logic             shift_en, at_last, border, any_strong, edge_px;

  always_comb begin
    in_class = CLS_NONE;
    if (in_dout >= HI_TH)
      in_class = CLS_STRONG;
    else if (in_dout >= LO_TH)
      in_class = CLS_WEAK;
  end

  // During flush the window is padded with NONE instead of real input data
  assign shift_class = (state == S_FLUSH) ? CLS_NONE : in_class;
  assign centre      = sr[WIDTH];

  assign any_strong = (shift_class      == CLS_STRONG) ||
                      (sr[0]            == CLS_STRONG) ||
                      (sr[1]            == CLS_STRONG) ||
                      (sr[WIDTH-1]      == CLS_STRONG) ||
                      (sr[WIDTH+1]      == CLS_STRONG) ||
                      (sr[2*WIDTH-1]    == CLS_STRONG) ||
                      (sr[2*WIDTH]      == CLS_STRONG) ||
                      (sr[2*WIDTH+1]    == CLS_STRONG);

  assign edge_px = (centre == CLS_STRONG) || ((centre == CLS_WEAK) && any_strong);
  assign border  = (out_row == '0) || (out_row == ROW_LAST) ||
                   (out_col == '0) || (out_col == COL_LAST);
  assign at_last = (out_row == ROW_LAST) && (out_col == COL_LAST);

  assign out_din = (!reset && (state != S_FILL) && edge_px && !border) ? 8'd255 : 8'd0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= S_FILL;
    else
      state <= next_state;
  end

  // Reads and writes are locked together in RUN so the window never slips
  always_comb begin
    next_state = state;
    in_rd_en   = 1'b0;
    out_wr_en  = 1'b0;
    shift_en   = 1'b0;
    case (state)
      S_FILL: begin
        in_rd_en = !in_empty;
        shift_en = !in_empty;
        if (!in_empty && (in_count == FILL_LAST))
          next_state = S_RUN;
      end
      S_RUN: begin
        in_rd_en  = !in_empty && !out_full;
        out_wr_en = !in_empty && !out_full;
        shift_en  = !in_empty && !out_full;
        if (!in_empty && !out_full && (in_count == RUN_LAST))
          next_state = S_FLUSH;
      end
      S_FLUSH: begin
        out_wr_en = !out_full;
        shift_en  = !out_full;
        if (!out_full && at_last)
          next_state = S_FILL;
      end
      default: next_state = S_FILL;
    endcase
    if (reset) begin
      in_rd_en  = 1'b0;
      out_wr_en = 1'b0;
      shift_en  = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_count <= '0;
      out_col  <= '0;
      out_row  <= '0;
    end else if ((state == S_FLUSH) && out_wr_en && at_last) begin
      in_count <= '0;
      out_col  <= '0;
      out_row  <= '0;
    end else begin
      if (in_rd_en)
        in_count <= in_count + 1'b1;
      if (out_wr_en) begin
        if (out_col == COL_LAST) begin
          out_col <= '0;
          out_row <= out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SR_LEN; i++)
        sr[i] <= CLS_NONE;
    end else if (shift_en) begin
      sr[0] <= shift_class;
      for (int i = 1; i < SR_LEN; i++)
        sr[i] <= sr[i-1];
    end
  end

endmodule

// File: tb/tb_hysteresis_thresh.sv
// Directed bench for hysteresis_thresh on an 8x6 frame: FIFO handshake
// protocol, edge decisions, border forcing, stalls and mid-frame reset.
module tb_hysteresis_thresh;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_rd_en;
  logic       in_empty;
  logic [7:0] in_dout;
  logic       out_wr_en;
  logic       out_full;
  logic [7:0] out_din;

  int num_checks = 0;
  int num_errors = 0;

  logic [7:0] stream_q [$];
  logic [7:0] exp_q    [$];
  logic [7:0] got_q    [$];
  logic [7:0] frame_px  [N];
  logic [7:0] frame_exp [N];

  hysteresis_thresh #(
    .WIDTH(W), .HEIGHT(H), .HIGH_THRESH(48), .LOW_THRESH(12)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_rd_en (in_rd_en),
    .in_empty (in_empty),
    .in_dout  (in_dout),
    .out_wr_en(out_wr_en),
    .out_full (out_full),
    .out_din  (out_din)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic new_frame();
    for (int i = 0; i < N; i++) begin
      frame_px[i]  = 8'd0;
      frame_exp[i] = 8'd0;
    end
  endtask

  task automatic put(input int r, input int c, input logic [7:0] v);
    frame_px[r*W + c] = v;
  endtask

  task automatic hit(input int idx);
    frame_exp[idx] = 8'd255;
  endtask

  task automatic commit();
    for (int i = 0; i < N; i++) begin
      stream_q.push_back(frame_px[i]);
      exp_q.push_back(frame_exp[i]);
    end
  endtask

  // Streams all committed frames; the handshake expected each cycle follows
  // from how many pixels have been read and written so far in this run.
  task automatic applyStimulus(input bit stall, input int abort_reads);
    int  target;
    int  reads;
    int  writes;
    int  cycles;
    int  budget;
    int  r;
    bit  first_wr;
    bit  exp_rd;
    bit  exp_wr;
    target   = (stream_q.size() / N) * N;
    reads    = 0;
    writes   = 0;
    cycles   = 0;
    budget   = target * 6 + 100;
    first_wr = 1'b1;
    got_q.delete();
    while (writes < target && cycles < budget) begin
      @(negedge clock);
      in_empty = (reads >= stream_q.size()) || (stall && ($urandom_range(0, 2) == 0));
      in_dout  = (reads < stream_q.size()) ? stream_q[reads] : 8'd0;
      out_full = stall && ($urandom_range(0, 2) == 0);
      #1;
      r = reads % N;
      if (r == 0 && reads > writes) begin
        exp_rd = 1'b0;
        exp_wr = !out_full;
      end else if (r <= W) begin
        exp_rd = !in_empty;
        exp_wr = 1'b0;
      end else begin
        exp_rd = !in_empty && !out_full;
        exp_wr = exp_rd;
      end
      checkOutput($sformatf("rd_en@r%0d/w%0d", reads, writes), 32'(in_rd_en), 32'(exp_rd));
      checkOutput($sformatf("wr_en@r%0d/w%0d", reads, writes), 32'(out_wr_en), 32'(exp_wr));
      if (out_wr_en === 1'b1) begin
        if (first_wr) begin
          checkOutput("first_write_read_no", 32'(reads + (in_rd_en ? 1 : 0)), 32'(W + 2));
          first_wr = 1'b0;
        end
        got_q.push_back(out_din);
        writes++;
      end
      if (in_rd_en === 1'b1)
        reads++;
      cycles++;
      if (abort_reads > 0 && reads >= abort_reads)
        break;
    end
    @(posedge clock);
    #1;
    in_empty = 1'b1;
    out_full = 1'b0;
    if (abort_reads == 0) begin
      checkOutput("write_count", 32'(writes), 32'(target));
      checkOutput("read_count", 32'(reads), 32'(target));
      for (int i = 0; i < got_q.size(); i++)
        checkOutput($sformatf("pix%0d_f%0d", i % N, i / N), 32'(got_q[i]), 32'(exp_q[i]));
    end
    stream_q.delete();
    exp_q.delete();
  endtask

  task automatic frame_zero();
    new_frame();
    commit();
  endtask

  task automatic frame_single_strong();
    new_frame();
    put(2, 3, 8'd200);
    hit(19);
    commit();
  endtask

  task automatic frame_weak_pair();
    new_frame();
    put(2, 3, 8'd20);
    put(3, 4, 8'd100);
    put(4, 1, 8'd20);
    hit(19);
    hit(28);
    commit();
  endtask

  task automatic frame_border();
    new_frame();
    put(0, 0, 8'd255);
    put(0, 4, 8'd255);
    put(5, 7, 8'd255);
    put(3, 0, 8'd255);
    commit();
  endtask

  task automatic check_reset_outputs(input string tag);
    #1;
    checkOutput({tag, "_rd_en"}, 32'(in_rd_en), 32'd0);
    checkOutput({tag, "_wr_en"}, 32'(out_wr_en), 32'd0);
    checkOutput({tag, "_din"}, 32'(out_din), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    in_empty = 1'b0;
    out_full = 1'b0;
    in_dout  = 8'hFF;
    repeat (2) @(negedge clock);
    check_reset_outputs("reset_init");
    @(negedge clock);
    reset    = 1'b0;
    in_empty = 1'b1;

    $display("[TB] Back-to-back directed frames, no stalls");
    frame_zero();
    frame_single_strong();
    frame_weak_pair();
    new_frame();
    put(2, 2, 8'd48);
    hit(18);
    commit();
    new_frame();
    put(2, 2, 8'd47);
    commit();
    // Low-threshold edges and a weak-to-weak chain that must not propagate
    new_frame();
    put(1, 1, 8'd12);
    put(2, 2, 8'd100);
    put(1, 5, 8'd11);
    put(2, 6, 8'd60);
    put(3, 3, 8'd30);
    put(4, 4, 8'd30);
    hit(9);
    hit(18);
    hit(22);
    hit(27);
    commit();
    frame_border();
    applyStimulus(1'b0, 0);

    $display("[TB] Same frames with random FIFO stalls");
    frame_single_strong();
    frame_weak_pair();
    frame_border();
    applyStimulus(1'b1, 0);

    $display("[TB] Reset after 20 reads of a saturated frame");
    new_frame();
    for (int i = 0; i < N; i++)
      frame_px[i] = 8'd255;
    commit();
    applyStimulus(1'b0, 20);
    @(negedge clock);
    reset    = 1'b1;
    in_empty = 1'b0;
    out_full = 1'b0;
    in_dout  = 8'hFF;
    check_reset_outputs("reset_mid");
    @(negedge clock);
    check_reset_outputs("reset_hold");
    @(negedge clock);
    reset    = 1'b0;
    in_empty = 1'b1;
    frame_single_strong();
    frame_zero();
    applyStimulus(1'b0, 0);
    checkOutput("reset_total_writes", 32'(got_q.size()), 32'(2 * N));

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
